alu_mul_seq: RTL and testbench

//  Multi-cycle 16x16 shift-add multiplier sequencer that borrows the shared 16-bit ALU for its add steps.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_port_mux.sv | 23 ++
 rtl/alu_mul_seq.sv | 127 ++++++++++++
 tb/tb_alu_mul_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and multiplier sequencer states.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_CMP   = 4'd5,
    ALU_ADDNF = 4'd6,
    ALU_SLL   = 4'd8,
    ALU_ROT   = 4'd9,
    ALU_SRL   = 4'd10,
    ALU_SRA   = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_port_mux.sv
// Operand/opcode mux in front of the shared ALU; the core always has priority over the sequencer.
module alu_port_mux
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         core_req,
  input  logic [3:0]   core_op,
  input  logic [W-1:0] core_a,
  input  logic [W-1:0] core_b,
  input  logic [3:0]   seq_op,
  input  logic [W-1:0] seq_a,
  input  logic [W-1:0] seq_b,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b
);

  assign alu_op = core_req ? core_op : seq_op;
  assign alu_a  = core_req ? core_a  : seq_a;
  assign alu_b  = core_req ? core_b  : seq_b;

endmodule

// File: rtl/alu_mul_seq.sv
// 16x16 shift-add multiplier that borrows the shared ALU for its add steps, yielding to the core.
// Optional build macro ALU_MUL_SIGNED_EN adds the is_signed input for two's-complement products.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int W     = 16,
  parameter int ITERS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef ALU_MUL_SIGNED_EN
  input  logic         is_signed,
`endif
  input  logic         start,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] prod_hi,
  output logic [W-1:0] prod_lo,
  input  logic         core_req,
  input  logic [3:0]   core_op,
  input  logic [W-1:0] core_a,
  input  logic [W-1:0] core_b,
  output logic [3:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_res,
  input  logic         alu_c,
  input  logic         alu_s,
  input  logic         alu_v
);

  localparam int CW = $clog2(ITERS);

  mul_state_e     state_q, state_d;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   hi_q, lo_q;
  logic [CW-1:0]  count_q;
  logic           sgn;

  logic           mbit, in_run, alu_step, step, last, sin;
  logic [W-1:0]   sum, hi_d, lo_d;
  alu_op_e        seq_op;
  logic [W-1:0]   seq_a, seq_b;

  assign mbit     = lo_q[0];
  assign in_run   = (state_q == RUN);
  assign alu_step = in_run & mbit;
  // A step needing the ALU waits while the core holds it; zero bits never wait.
  assign step     = in_run & (~mbit | ~core_req);
  assign last     = (count_q == CW'(ITERS - 1));

  // Signed mode subtracts on the final multiplier bit, which carries negative weight.
  assign seq_op = (alu_step && sgn && last) ? ALU_SUB : ALU_ADD;
  assign seq_a  = alu_step ? hi_q    : '0;
  assign seq_b  = alu_step ? mcand_q : '0;

  assign sum  = mbit ? alu_res : hi_q;
  assign sin  = sgn ? (alu_step ? (alu_s ^ alu_v) : hi_q[W-1])
                    : (alu_step & alu_c);
  assign hi_d = {sin, sum[W-1:1]};
  assign lo_d = {sum[0], lo_q[W-1:1]};

  alu_port_mux #(.W(W)) u_mux (
    .core_req (core_req),
    .core_op  (core_op),
    .core_a   (core_a),
    .core_b   (core_b),
    .seq_op   (seq_op),
    .seq_a    (seq_a),
    .seq_b    (seq_b),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (step && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

`ifdef ALU_MUL_SIGNED_EN
  logic sgn_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         sgn_q <= 1'b0;
    else if (state_q == IDLE && start)  sgn_q <= is_signed;
  end
  assign sgn = sgn_q;
`else
  assign sgn = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else if (state_q == IDLE && start) begin
      mcand_q <= src_a;
      hi_q    <= '0;
      lo_q    <= src_b;
      count_q <= '0;
    end else if (step) begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_q + CW'(1);
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign prod_hi = hi_q;
  assign prod_lo = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq paired with a behavioural ALU; table vectors, corner sequences, random runs.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_a = '0, src_b = '0;
  logic        ready, done;
  logic [15:0] prod_hi, prod_lo;
  logic        core_req = 1'b0;
  logic [3:0]  core_op = '0;
  logic [15:0] core_a = '0, core_b = '0;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        alu_c, alu_s, alu_v;
`ifdef ALU_MUL_SIGNED_EN
  logic        is_signed = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ALU_MUL_SIGNED_EN
    .is_signed(is_signed),
`endif
    .start    (start),
    .src_a    (src_a),
    .src_b    (src_b),
    .ready    (ready),
    .done     (done),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo),
    .core_req (core_req),
    .core_op  (core_op),
    .core_a   (core_a),
    .core_b   (core_b),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_res  (alu_res),
    .alu_c    (alu_c),
    .alu_s    (alu_s),
    .alu_v    (alu_v)
  );

  // Behavioural shared ALU
  logic [16:0] t;
  always_comb begin
    t = '0;
    alu_v = 1'b0;
    case (alu_op)
      4'd0: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
      end
      4'd1: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_v = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
      end
      4'd2:    t = {1'b0, alu_a & alu_b};
      4'd3:    t = {1'b0, alu_a | alu_b};
      4'd4:    t = {1'b0, alu_a ^ alu_b};
      default: t = {1'b0, alu_a};
    endcase
    alu_res = t[15:0];
    alu_c   = t[16];
    alu_s   = t[15];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    logic signed [31:0] sp;
    logic [31:0] up;
    sp = $signed(a) * $signed(b);
    up = a * b;
    return sgn ? sp : up;
  endfunction

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    bit          sgn;
    int          stall_s;
    int          stall_l;
    bit          core_all;
    bit          rand_core;
    int          restart_at;
    logic [31:0] exp_prod;
    int          exp_cyc;
  } vec_t;

  // Start at a negedge (cycle 0) and count negedges until done is seen.
  task automatic run_mul(input vec_t v);
    int cyc;
    bit got;
    logic [31:0] prod;
    @(negedge clk);
    chk({v.name, "_ready"}, 32'(ready), 32'd1);
    src_a = v.a;
    src_b = v.b;
`ifdef ALU_MUL_SIGNED_EN
    is_signed = v.sgn;
`endif
    start = 1'b1;
    core_req = v.core_all;
    cyc = 0;
    got = 1'b0;
    prod = '0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        prod = {prod_hi, prod_lo};
        start = 1'b1;
        src_a = 16'h1111;
        src_b = 16'h2222;
        core_req = 1'b0;
      end else begin
        if (cyc == v.restart_at) begin
          start = 1'b1;
          src_a = 16'($urandom);
          src_b = 16'($urandom);
        end
        core_req = v.core_all || (cyc >= v.stall_s && cyc < v.stall_s + v.stall_l) ||
                   (v.rand_core && ($urandom_range(0, 3) == 0));
        core_op = 4'($urandom);
        core_a  = 16'($urandom);
        core_b  = 16'($urandom);
        #1;
        if (core_req && (cyc == v.stall_s || v.core_all))
          chk({v.name, "_alu_core"}, {alu_op, alu_a, alu_b[11:0]}, {core_op, core_a, core_b[11:0]});
      end
    end
    if (!got) chk({v.name, "_timeout"}, 32'(cyc), 32'd0);
    chk({v.name, "_prod"}, prod, v.exp_prod);
    if (v.exp_cyc >= 0) chk({v.name, "_cycles"}, 32'(cyc), 32'(v.exp_cyc));
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "_post"}, {30'd0, ready, done}, 32'd2);
    chk({v.name, "_hold"}, {prod_hi, prod_lo}, v.exp_prod);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [15:0] ra, rb;
    bit rs;

    tbl.push_back('{"m3x5",     16'h0003, 16'h0005, 1'b0, 0, 0, 1'b0, 1'b0, -1, 32'h0000_000F, 17});
    tbl.push_back('{"mffff",    16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 1'b0, 1'b0, -1, 32'hFFFE_0001, 17});
    tbl.push_back('{"mzero_a",  16'h0000, 16'h1234, 1'b0, 0, 0, 1'b0, 1'b0, -1, 32'h0000_0000, 17});
    tbl.push_back('{"mstall4",  16'h0001, 16'hFFFF, 1'b0, 5, 4, 1'b0, 1'b0, -1, 32'h0000_FFFF, 21});
    tbl.push_back('{"mzero_b",  16'hABCD, 16'h0000, 1'b0, 0, 0, 1'b1, 1'b0, -1, 32'h0000_0000, 17});
    tbl.push_back('{"mrestart", 16'h1234, 16'h5678, 1'b0, 0, 0, 1'b0, 1'b0, 6,  32'h0626_0060, 17});
    tbl.push_back('{"m8000",    16'h8000, 16'h8000, 1'b0, 0, 0, 1'b0, 1'b0, -1, 32'h4000_0000, 17});
`ifdef ALU_MUL_SIGNED_EN
    tbl.push_back('{"sfffe3",   16'hFFFE, 16'h0003, 1'b1, 0, 0, 1'b0, 1'b0, -1, 32'hFFFF_FFFA, 17});
    tbl.push_back('{"s8000",    16'h8000, 16'h8000, 1'b1, 0, 0, 1'b0, 1'b0, -1, 32'h4000_0000, 17});
    tbl.push_back('{"sneg1",    16'hFFFF, 16'hFFFF, 1'b1, 3, 2, 1'b0, 1'b0, -1, 32'h0000_0001, 19});
`endif

    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", {29'd0, ready, done, 1'b0}, 32'd4);
    chk("rst_prod", {prod_hi, prod_lo}, 32'd0);
    chk("rst_alu_idle", {12'd0, alu_op, alu_a}, 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_mul(tbl[i]);

    // Reset asserted in the middle of a run
    @(negedge clk);
    src_a = 16'h1234;
    src_b = 16'h5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_ready", {30'd0, ready, done}, 32'd2);
    chk("midrun_rst_prod", {prod_hi, prod_lo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul('{"after_rst", 16'h0007, 16'h0009, 1'b0, 0, 0, 1'b0, 1'b0, -1, 32'h0000_003F, 17});

    // Random operands with random core contention
    for (int k = 0; k < 24; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 6 == 0) rb = 16'hFFFF;
`ifdef ALU_MUL_SIGNED_EN
      rs = bit'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      v = '{"rnd", ra, rb, rs, 0, 0, 1'b0, 1'b1, -1, ref_prod(ra, rb, rs), -1};
      run_mul(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
